// File: rtl/seg7_scan_counter.sv
// DIGITS-wide BCD up/down counter with programmable prescaler and a multiplexed seven-segment scan.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seg7_scan_counter #(
  parameter int          DIGITS    = 4,
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter logic [15:0] SCAN_DIV  = 16'd10_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            tick_sel,
  input  logic                  up_dn,
  input  logic                  hold,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic                  tick,
  output logic                  wrap,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_en
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [23:0]          presc_q, presc_d, compare;
  logic [4*DIGITS-1:0]  value_q, value_d;
  logic                 tick_q, tick_d, wrap_q, wrap_d;
  logic [15:0]          scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic [6:0]           segments_q, segments_d;
  logic [DIGITS-1:0]    digit_en_q, digit_en_d;
  logic                 carry;
  logic [3:0]           dig, cur_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign compare = (tick_sel == 8'd0) ? MAX_COUNT : {6'b0, tick_sel, 10'b0};

  // Using >= lets a freshly lowered compare expire immediately instead of running to 2^24.
  always_comb begin
    presc_d = presc_q;
    value_d = value_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    dig     = 4'd0;
    if (clear) begin
      presc_d = '0;
      value_d = '0;
    end else if (!hold) begin
      if (presc_q >= compare) begin
        presc_d = '0;
        tick_d  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          dig = value_q[4*i +: 4];
          if (carry) begin
            if (up_dn) begin
              if (dig == 4'd9) begin
                value_d[4*i +: 4] = 4'd0;
              end else begin
                value_d[4*i +: 4] = dig + 4'd1;
                carry = 1'b0;
              end
            end else begin
              if (dig == 4'd0) begin
                value_d[4*i +: 4] = 4'd9;
              end else begin
                value_d[4*i +: 4] = dig - 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
        wrap_d = carry;
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q >= SCAN_DIV - 16'd1) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              seen_nonzero;

  // A digit is blank while it and everything above it are zero; digit 0 never blanks.
  always_comb begin
    blank        = '0;
    seen_nonzero = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen_nonzero = seen_nonzero | (value_q[4*i +: 4] != 4'd0);
      blank[i]     = !seen_nonzero;
    end
  end
`endif

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) cur_digit = value_q[4*i +: 4];
    end
    digit_en_d = DIGITS'(1) << scan_idx_q;
    segments_d = seg_decode(cur_digit);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (blank[scan_idx_q]) segments_d = 7'h00;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      value_q    <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      segments_q <= '0;
      digit_en_q <= '0;
    end else begin
      presc_q    <= presc_d;
      value_q    <= value_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      segments_q <= segments_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign value    = value_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign segments = segments_q;
  assign digit_en = digit_en_q;
endmodule

// File: doc/seg7_scan_counter.md
# seg7_scan_counter

Parametrised successor to the single-digit seven-segment demo counter. It holds a DIGITS-wide BCD counter that counts up or down from a programmable prescaler tick, and drives a time-multiplexed common-segment display with one-hot digit enables. It sits directly behind the dedicated output pins in the top-level wrapper, with the compare override taken from the input switches.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits, legal 1..8.
- MAX_COUNT, 24'd10_000_000: prescaler compare used when `tick_sel == 0`.
- SCAN_DIV, 16'd10_000: clock cycles per display digit slot, legal ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick_sel  in  8  prescaler override; nonzero gives compare = {6'b0, tick_sel, 10'b0}.
- up_dn  in  1  1 = count up, 0 = count down.
- hold  in  1  freezes prescaler and counter.
- clear  in  1  synchronous clear of prescaler and counter.
- value  out  4*DIGITS  BCD count; digit i is at [4i+3:4i], digit 0 is least significant.
- tick  out  1  one-cycle pulse on each prescaler expiry.
- wrap  out  1  one-cycle pulse when the counter wraps.
- segments  out  7  active-high segments, bit0 = a … bit6 = g, registered.
- digit_en  out  DIGITS  one-hot active-high digit select, registered.

## Operation
- Reset: all outputs and internal state are 0, including prescaler, scan divider, scan index, value, tick, wrap, segments and digit_en.
- Prescaler (24 bit):
  - compare = MAX_COUNT when tick_sel is 0, otherwise tick_sel<<10.
  - While hold = 0, the prescaler increments each cycle.
  - When prescaler ≥ compare, it loads 0 and the counter steps. Using ≥ means a compare lowered below the current prescaler value expires on the next cycle, with no runaway to 2^24.
- Counter step (BCD, ripple carry/borrow across digits):
  - Up: a digit at 9 goes to 0 and carries; otherwise it increments.
  - Down: a digit at 0 goes to 9 and borrows; otherwise it decrements.
  - Up from all-9s gives all-0s; down from all-0s gives all-9s. Both assert wrap.
- Priority: clear > hold > step. clear zeroes prescaler and value and suppresses tick and wrap in that cycle. hold keeps prescaler and value, and tick stays 0.
- up_dn is sampled on the step edge only; changing it between ticks has no other effect.
- Scan:
  - The scan divider counts 0..SCAN_DIV-1 continuously and is not affected by hold or clear.
  - At SCAN_DIV-1 the scan index advances 0→1→…→DIGITS-1→0.
- Display register (every cycle):
  - digit_en gets a one-hot of the scan index.
  - segments gets the decode of value digit[index], using the current value.
  - Decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, g..a). Codes 10–15 cannot occur and decode to 00.

## Timing
- tick and wrap are registered and assert in the same cycle the new value is visible. Both are high for exactly one cycle.
- Tick period is compare+1 cycles.
- segments and digit_en lag the scan index and value by 1 cycle. They always update together, so no mismatched digit/segment pair is ever driven.
- After reset is released, the first clock produces digit_en = 1 and segments = 3F.
- Asserting reset mid-count or mid-scan immediately forces all outputs to 0, asynchronously. Operation restarts from the reset state.
- tick_sel is used combinationally in the compare and takes effect on the next edge.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined: digit i > 0 is blanked (segments = 00) when it and every more-significant digit are 0.
  - digit_en is still asserted during a blanked slot.
  - Digit 0 is never blanked.
- Macro undefined: all digits always display, including leading zeros.

## Test plan
Bench parameters for all scenarios: DIGITS = 2, MAX_COUNT = 4, SCAN_DIV = 2.
1. Reset: hold reset 3 cycles, then release -> all outputs 0 during reset; the first edge after release gives digit_en = 01 and segments = 3F.
2. Up count: tick_sel = 0, up_dn = 1 -> tick every 5 cycles; value 00→01→…→99; the 100th tick gives value 00 with wrap = 1 for one cycle.
3. Down count from 00: up_dn = 0 -> first tick gives value 99 and wrap = 1; the next tick gives 98.
4. Compare override: tick_sel = 1 -> ticks exactly 1025 cycles apart. Then switch to tick_sel = 0 while the prescaler is at 500 -> next tick on the following cycle, then every 5 cycles.
5. Control priority and async reset:
   - clear asserted in a tick cycle -> value 00, tick = 0, wrap = 0.
   - hold for 20 cycles -> value unchanged, no tick.
   - reset asserted mid-count at value 37 -> outputs 0 with no clock edge required.
6. Scan: value 05 -> digit_en alternates 01/10 every 2 cycles; segments = 6D with 01, and 3F with 10. With SEG7_LEADING_ZERO_BLANK_EN, segments = 00 with 10.
